// File: rtl/calc_hex_checker.sv
// Self-check sequencer for the 4-bit signed calculator: sweeps every
// {KEY,SW} vector, decodes the seven-segment outputs and tallies results.
module calc_hex_checker #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic        CLOCK_50,
    input  logic        reset,
    input  logic        start,
    output logic [2:0]  KEY_drv,
    output logic [7:0]  SW_drv,
    input  logic [6:0]  HEX7,
    input  logic [6:0]  HEX6,
    input  logic [6:0]  HEX5,
    input  logic [6:0]  HEX4,
    input  logic [6:0]  HEX3,
    input  logic [6:0]  HEX2,
    input  logic [6:0]  HEX0,
    output logic        busy,
    output logic        done,
    output logic [11:0] pass_count,
    output logic [11:0] fail_count,
    output logic [10:0] first_fail,
    output logic        fail_seen
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_APPLY,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_nx;
    logic [10:0] vec;
    logic [3:0]  cnt;

    // {valid, magnitude} for one active-low digit
    function automatic logic [4:0] digit(input logic [6:0] s);
        logic [4:0] d;
        unique case (s)
            7'h40:   d = {1'b1, 4'd0};
            7'h79:   d = {1'b1, 4'd1};
            7'h24:   d = {1'b1, 4'd2};
            7'h30:   d = {1'b1, 4'd3};
            7'h19:   d = {1'b1, 4'd4};
            7'h12:   d = {1'b1, 4'd5};
            7'h02:   d = {1'b1, 4'd6};
            7'h78:   d = {1'b1, 4'd7};
            7'h00:   d = {1'b1, 4'd8};
            default: d = 5'd0;
        endcase
        return d;
    endfunction

    // {valid, 5-bit signed value}; a negative zero is invalid
    function automatic logic [5:0] sval(input logic [6:0] sg,
                                        input logic [6:0] mg);
        logic [4:0] d;
        logic       neg;
        logic       pos;
        logic [4:0] m;
        d   = digit(mg);
        neg = (sg == 7'h3F);
        pos = (sg == 7'h7F);
        m   = {1'b0, d[3:0]};
        return {d[4] & (neg | pos) & ~(neg & (d[3:0] == 4'd0)),
                neg ? 5'd0 - m : m};
    endfunction

    logic [2:0] key;
    logic [4:0] a5;
    logic [4:0] b5;
    logic [4:0] r5;
    logic       ovf;
    logic [5:0] a_d;
    logic [5:0] b_d;
    logic [5:0] r_d;
    logic       vec_ok;

    assign key = vec[10:8];
    assign a5  = {vec[7], vec[7:4]};
    assign b5  = {vec[3], vec[3:0]};

    always_comb begin
        r5 = 5'd0;
        unique case (1'b1)
            key[1:0] == 2'b00: r5 = a5 + b5;
            key == 3'b001:     r5 = a5 - b5;
            key == 3'b101:     r5 = b5 - a5;
            key[2:1] == 2'b01: r5 = b5[4] ? 5'd0 - b5 : b5;
            key[2:1] == 2'b11: r5 = a5[4] ? 5'd0 - a5 : a5;
            default:           r5 = 5'd0;
        endcase
    end

    assign ovf = r5[4] ^ r5[3];
    assign a_d = sval(HEX7, HEX6);
    assign b_d = sval(HEX5, HEX4);
    assign r_d = sval(HEX3, HEX2);

    // result digits only matter when the calculator is not flagging overflow
    assign vec_ok = a_d[5] && (a_d[4:0] == a5)
                 && b_d[5] && (b_d[4:0] == b5)
                 && (ovf ? (HEX0 == 7'h06)
                         : ((HEX0 == 7'h7F) && r_d[5] && (r_d[4:0] == r5)));

    always_comb begin
        state_nx = state;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) state_nx = S_APPLY;
            end
            S_APPLY: begin
                busy     = 1'b1;
                state_nx = S_SETTLE;
            end
            S_SETTLE: begin
                busy = 1'b1;
                if (cnt == 4'(SETTLE_CYCLES - 1)) state_nx = S_SAMPLE;
            end
            S_SAMPLE: begin
                busy     = 1'b1;
                state_nx = (vec == 11'h7FF) ? S_DONE : S_APPLY;
            end
            S_DONE: begin
                done = 1'b1;
                if (start) state_nx = S_APPLY;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state      <= S_IDLE;
            vec        <= 11'd0;
            cnt        <= 4'd0;
            KEY_drv    <= 3'd0;
            SW_drv     <= 8'd0;
            pass_count <= 12'd0;
            fail_count <= 12'd0;
            first_fail <= 11'd0;
            fail_seen  <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec        <= 11'd0;
                        pass_count <= 12'd0;
                        fail_count <= 12'd0;
                        first_fail <= 11'd0;
                        fail_seen  <= 1'b0;
                    end
                end
                S_APPLY: begin
                    {KEY_drv, SW_drv} <= vec;
                    cnt               <= 4'd0;
                end
                S_SETTLE: cnt <= cnt + 4'd1;
                S_SAMPLE: begin
                    if (vec_ok) begin
                        pass_count <= pass_count + 12'd1;
                    end else begin
                        fail_count <= fail_count + 12'd1;
                        if (!fail_seen) begin
                            first_fail <= vec;
                            fail_seen  <= 1'b1;
                        end
                    end
                    if (vec != 11'h7FF) vec <= vec + 11'd1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_calc_hex_checker.sv
// Directed bench: behavioural calculator with injectable display faults
// driven by the checker under test.
module tb_calc_hex_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [2:0]  key_drv;
    logic [7:0]  sw_drv;
    logic [6:0]  hex7, hex6, hex5, hex4, hex3, hex2, hex0;
    logic        busy, done;
    logic [11:0] pass_count, fail_count;
    logic [10:0] first_fail;
    logic        fail_seen;
    int          mode;
    int          total = 0;
    int          bad = 0;

    always #5 clk = ~clk;

    calc_hex_checker dut (
        .CLOCK_50   (clk),
        .reset      (reset),
        .start      (start),
        .KEY_drv    (key_drv),
        .SW_drv     (sw_drv),
        .HEX7       (hex7),
        .HEX6       (hex6),
        .HEX5       (hex5),
        .HEX4       (hex4),
        .HEX3       (hex3),
        .HEX2       (hex2),
        .HEX0       (hex0),
        .busy       (busy),
        .done       (done),
        .pass_count (pass_count),
        .fail_count (fail_count),
        .first_fail (first_fail),
        .fail_seen  (fail_seen)
    );

    function automatic logic [6:0] seg7(input int m);
        case (m)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            default: return 7'h7F;
        endcase
    endfunction

    always_comb begin
        int a, b, r;
        logic ov;
        a = int'($signed(sw_drv[7:4]));
        b = int'($signed(sw_drv[3:0]));
        case (key_drv)
            3'd0, 3'd4: r = a + b;
            3'd1:       r = a - b;
            3'd5:       r = b - a;
            3'd2, 3'd3: r = (b < 0) ? -b : b;
            default:    r = (a < 0) ? -a : a;
        endcase
        ov   = (r > 7) || (r < -8);
        hex7 = (a < 0) ? 7'h3F : 7'h7F;
        hex6 = seg7((a < 0) ? -a : a);
        hex5 = (b < 0) ? 7'h3F : 7'h7F;
        hex4 = seg7((b < 0) ? -b : b);
        hex3 = (r < 0) ? 7'h3F : 7'h7F;
        hex2 = seg7((r < 0) ? -r : r);
        hex0 = ov ? 7'h06 : 7'h7F;
        if (mode == 1 && {key_drv, sw_drv} == 11'h071) hex0 = 7'h7F;
        if (mode == 2 && {key_drv, sw_drv} == 11'h199) begin
            hex3 = 7'h3F;
            hex2 = 7'h40;
        end
        if (mode == 3 && key_drv == 3'd6 && sw_drv[7:4] == 4'h8) hex0 = 7'h7F;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_vals();
        chk("rst_key", 32'(key_drv), 0);
        chk("rst_sw", 32'(sw_drv), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_pass", 32'(pass_count), 0);
        chk("rst_fail", 32'(fail_count), 0);
        chk("rst_first", 32'(first_fail), 0);
        chk("rst_seen", 32'(fail_seen), 0);
    endtask

    // n = clock edges from the start edge until done is seen
    task automatic sweep(input int mid_start, output int n);
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        chk("busy_after_start", 32'(busy), 1);
        chk("done_cleared", 32'(done), 0);
        while (!done && n < 13000) begin
            start = (mid_start > 0 && n == mid_start);
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        chk("sweep_finished", 32'(done), 1);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        mode  = 0;
        repeat (3) @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;

        sweep(0, n);
        chk("clean_cycles", 32'(n), 12288);
        chk("clean_pass", 32'(pass_count), 2048);
        chk("clean_fail", 32'(fail_count), 0);
        chk("clean_seen", 32'(fail_seen), 0);
        repeat (5) @(negedge clk);
        chk("done_held", 32'(done), 1);
        chk("idle_busy", 32'(busy), 0);
        chk("drv_hold", 32'({key_drv, sw_drv}), 32'h7FF);

        mode = 1;
        sweep(0, n);
        chk("ovf_blank_pass", 32'(pass_count), 2047);
        chk("ovf_blank_fail", 32'(fail_count), 1);
        chk("ovf_blank_first", 32'(first_fail), 32'h071);
        chk("ovf_blank_seen", 32'(fail_seen), 1);

        mode = 2;
        sweep(0, n);
        chk("neg_zero_fail", 32'(fail_count), 1);
        chk("neg_zero_first", 32'(first_fail), 32'h199);

        mode = 3;
        sweep(0, n);
        chk("abs8_pass", 32'(pass_count), 2032);
        chk("abs8_fail", 32'(fail_count), 16);
        chk("abs8_first", 32'(first_fail), 32'h680);

        mode = 1;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        n = 0;
        while ({key_drv, sw_drv} != 11'd300 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk("reached_vec300", 32'({key_drv, sw_drv}), 300);
        chk("mid_pass", 32'(pass_count), 299);
        chk("mid_fail", 32'(fail_count), 1);
        chk("mid_seen", 32'(fail_seen), 1);
        reset = 1'b1;
        @(negedge clk);
        chk_reset_vals();
        reset = 1'b0;
        mode  = 0;
        @(negedge clk);
        sweep(0, n);
        chk("restart_cycles", 32'(n), 12288);
        chk("restart_pass", 32'(pass_count), 2048);

        sweep(5000, n);
        chk("busy_start_cycles", 32'(n), 12288);
        chk("busy_start_pass", 32'(pass_count), 2048);
        chk("busy_start_fail", 32'(fail_count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
